// File: rtl/buck_pwm_pkg.sv
// Shared types and helpers for the buck converter gate-drive generator.
package buck_pwm_pkg;

    localparam int DEF_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SOFT_START = 2'd1,
        RUN        = 2'd2,
        DRAIN      = 2'd3
    } state_t;

    // A period shorter than MIN_OFF+1 cannot hold even one on-cycle plus the
    // mandatory off-time, so it is stretched.
    function automatic logic [31:0] clamp_period(input logic [31:0] period,
                                                 input logic [31:0] min_off);
        return (period < min_off + 32'd1) ? (min_off + 32'd1) : period;
    endfunction

    // On-time is limited so every period keeps at least MIN_OFF low cycles.
    function automatic logic [31:0] clamp_duty(input logic [31:0] duty,
                                               input logic [31:0] period,
                                               input logic [31:0] min_off);
        return (duty > period - min_off) ? (period - min_off) : duty;
    endfunction

endpackage

// File: rtl/buck_pwm_ctrl_counter.sv
// Period counter: holds cnt and the active period, flags the wrap cycle.
module pwm_period_counter
    import buck_pwm_pkg::*;
#(
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int DEF_PERIOD = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic [CNT_WIDTH-1:0] cnt_next,
    output logic                 wrap
);

    logic [CNT_WIDTH-1:0] period_act;

    // Wrap on the last count of the period; the >= keeps cnt bounded even if
    // the period register were ever below the running count.
    always_comb begin
        wrap = run && (cnt >= period_act - CNT_WIDTH'(1));
        if (!run || wrap) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + CNT_WIDTH'(1);
        end
    end

    // Counter and period register; a new period is only ever loaded at a wrap or while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            period_act <= CNT_WIDTH'(DEF_PERIOD);
        end else begin
            cnt <= cnt_next;
            if (load) begin
                period_act <= load_val;
            end
        end
    end

endmodule

// File: rtl/buck_pwm_ctrl.sv
// Gate-drive PWM generator for the buck plant: soft-start ramp, shadowed
// period/duty config applied at period boundaries, drain-to-idle on disable.
module buck_pwm_ctrl
    import buck_pwm_pkg::*;
#(
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int DEF_PERIOD = 200,
    parameter int DEF_DUTY   = 100,
    parameter int SS_STEP    = 10,
    parameter int MIN_OFF    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_duty,
    output logic                 gate,
    output logic                 period_start,
    output logic                 ss_done,
    output logic [CNT_WIDTH-1:0] cnt
);

    state_t               state, state_d;
    logic [CNT_WIDTH-1:0] duty_tgt, duty_tgt_d;
    logic [CNT_WIDTH-1:0] duty_eff, duty_eff_d;
    logic [CNT_WIDTH-1:0] pend_period, pend_duty;
    logic                 pend_vld, pend_vld_d;
    logic [CNT_WIDTH-1:0] cnt_next, new_period;
    logic                 wrap, capture, apply, run;
    logic                 gate_d, period_start_d;
    logic [31:0]          per_clamped, duty_clamped, ss_sum, ss_clamped;

    assign run = (state != IDLE);

    pwm_period_counter #(
        .CNT_WIDTH  (CNT_WIDTH),
        .DEF_PERIOD (DEF_PERIOD)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .load     (apply),
        .load_val (new_period),
        .cnt      (cnt),
        .cnt_next (cnt_next),
        .wrap     (wrap)
    );

    // Shadow slot: capture on handshake, apply at the wrap (or straight away when idle).
    always_comb begin
        capture      = cfg_valid && cfg_ready;
        apply        = pend_vld && (wrap || (state == IDLE));
        per_clamped  = clamp_period(32'(pend_period), 32'(MIN_OFF));
        duty_clamped = clamp_duty(32'(pend_duty), per_clamped, 32'(MIN_OFF));
        new_period   = CNT_WIDTH'(per_clamped);
        duty_tgt_d   = apply ? CNT_WIDTH'(duty_clamped) : duty_tgt;
        if (capture) begin
            pend_vld_d = 1'b1;
        end else if (apply) begin
            pend_vld_d = 1'b0;
        end else begin
            pend_vld_d = pend_vld;
        end
    end

    // Next state, effective duty, and the registered-output next values.
    always_comb begin
        state_d    = state;
        duty_eff_d = duty_eff;
        ss_sum     = 32'(duty_eff) + 32'(SS_STEP);
        ss_clamped = (ss_sum < 32'(duty_tgt_d)) ? ss_sum : 32'(duty_tgt_d);
        case (state)
            IDLE: begin
                if (en) begin
                    state_d    = SOFT_START;
                    duty_eff_d = '0;
                end
            end
            SOFT_START: begin
                if (!en) begin
                    state_d = DRAIN;
                end else if (wrap) begin
                    duty_eff_d = CNT_WIDTH'(ss_clamped);
                    if (ss_clamped == 32'(duty_tgt_d)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = DRAIN;
                end else if (wrap) begin
                    duty_eff_d = duty_tgt_d;
                end
            end
            DRAIN: begin
                if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are computed from next-cycle values so gate, cnt and
        // period_start line up once registered.
        gate_d         = ((state_d == SOFT_START) || (state_d == RUN)) && (cnt_next < duty_eff_d);
        period_start_d = (state_d != IDLE) && (cnt_next == '0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Shadow/target registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_tgt     <= CNT_WIDTH'(DEF_DUTY);
            duty_eff     <= '0;
            pend_vld     <= 1'b0;
            pend_period  <= '0;
            pend_duty    <= '0;
            cfg_ready    <= 1'b1;
            gate         <= 1'b0;
            period_start <= 1'b0;
            ss_done      <= 1'b0;
        end else begin
            duty_tgt     <= duty_tgt_d;
            duty_eff     <= duty_eff_d;
            pend_vld     <= pend_vld_d;
            cfg_ready    <= !pend_vld_d;
            gate         <= gate_d;
            period_start <= period_start_d;
            ss_done      <= (state_d == RUN);
            if (capture) begin
                pend_period <= cfg_period;
                pend_duty   <= cfg_duty;
            end
        end
    end

endmodule

// File: tb/tb_buck_pwm_ctrl.sv
// Directed bench for buck_pwm_ctrl: soft start, config shadowing, clamps,
// drain and mid-run reset, with hand-computed expectations.
module tb_buck_pwm_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, en, cfg_valid;
    logic         cfg_ready, gate, period_start, ss_done;
    logic [W-1:0] cfg_period, cfg_duty, cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    buck_pwm_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .gate         (gate),
        .period_start (period_start),
        .ss_done      (ss_done),
        .cnt          (cnt)
    );

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_duty = '0;
        repeat (3) @(negedge clk);
        tests++; if (cnt !== 16'd0)      begin fails++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        tests++; if (gate !== 1'b0)      begin fails++; $display("FAIL reset_gate: got %0b expected 0", gate); end
        tests++; if (period_start !== 1'b0) begin fails++; $display("FAIL reset_ps: got %0b expected 0", period_start); end
        tests++; if (ss_done !== 1'b0)   begin fails++; $display("FAIL reset_ss_done: got %0b expected 0", ss_done); end
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready: got %0b expected 1", cfg_ready); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (cnt !== 16'd0 || period_start !== 1'b0) begin
            fails++; $display("FAIL idle_hold: cnt %0d ps %0b expected 0 0", cnt, period_start);
        end
    endtask

    task automatic test_soft_start();
        int on, bad, exp_on;
        en = 1'b1;
        @(negedge clk);
        tests++; if (period_start !== 1'b1 || cnt !== 16'd0) begin
            fails++; $display("FAIL ss_entry: ps %0b cnt %0d expected 1 0", period_start, cnt);
        end
        for (int p = 0; p < 12; p++) begin
            on = 0; bad = 0;
            for (int i = 0; i < 200; i++) begin
                if (gate) on++;
                if (int'(cnt) != i) bad++;
                if (period_start !== (i == 0)) bad++;
                if (ss_done !== (p >= 10)) bad++;
                @(negedge clk);
            end
            exp_on = (p < 10) ? p * 10 : 100;
            tests++; if (on != exp_on) begin
                fails++; $display("FAIL ss_ontime p%0d: got %0d expected %0d", p, on, exp_on);
            end
            tests++; if (bad != 0) begin
                fails++; $display("FAIL ss_seq p%0d: got %0d bad samples expected 0", p, bad);
            end
        end
    endtask

    task automatic test_cfg_apply();
        int on;
        on = 0;
        for (int i = 0; i < 200; i++) begin
            if (gate) on++;
            if (i == 50) begin
                cfg_period = 16'd400; cfg_duty = 16'd300; cfg_valid = 1'b1;
            end
            if (i == 51) begin
                tests++; if (cfg_ready !== 1'b0) begin
                    fails++; $display("FAIL cfg_ready_drop: got %0b expected 0", cfg_ready);
                end
                cfg_valid = 1'b0;
            end
            @(negedge clk);
        end
        tests++; if (on != 100) begin fails++; $display("FAIL cfg_old_period_on: got %0d expected 100", on); end
        tests++; if (cfg_ready !== 1'b1 || period_start !== 1'b1) begin
            fails++; $display("FAIL cfg_apply_edge: ready %0b ps %0b expected 1 1", cfg_ready, period_start);
        end
        on = 0;
        for (int i = 0; i < 400; i++) begin
            if (gate) on++;
            if (i == 399) begin
                tests++; if (cnt !== 16'd399) begin
                    fails++; $display("FAIL cfg_new_period_end: got %0d expected 399", cnt);
                end
            end
            @(negedge clk);
        end
        tests++; if (on != 300) begin fails++; $display("FAIL cfg_new_on: got %0d expected 300", on); end
        tests++; if (cnt !== 16'd0) begin fails++; $display("FAIL cfg_new_wrap: got %0d expected 0", cnt); end
    endtask

    task automatic test_min_clamp();
        int bad;
        cfg_period = 16'd1; cfg_duty = 16'd50; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (399) @(negedge clk);
        tests++; if (cfg_ready !== 1'b1 || cnt !== 16'd0) begin
            fails++; $display("FAIL clamp_apply: ready %0b cnt %0d expected 1 0", cfg_ready, cnt);
        end
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (gate !== (i % 3 == 0)) bad++;
            if (int'(cnt) != i % 3) bad++;
            @(negedge clk);
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL clamp_pattern: got %0d bad samples expected 0", bad); end
    endtask

    task automatic test_back_to_back();
        int on;
        cfg_period = 16'd20; cfg_duty = 16'd5; cfg_valid = 1'b1;
        @(negedge clk);
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL b2b_first_capture: got %0b expected 0", cfg_ready); end
        cfg_period = 16'd10; cfg_duty = 16'd8;
        @(negedge clk);
        tests++; if (cfg_ready !== 1'b0 || cnt !== 16'd2) begin
            fails++; $display("FAIL b2b_held: ready %0b cnt %0d expected 0 2", cfg_ready, cnt);
        end
        @(negedge clk);
        tests++; if (cfg_ready !== 1'b1 || cnt !== 16'd0) begin
            fails++; $display("FAIL b2b_first_apply: ready %0b cnt %0d expected 1 0", cfg_ready, cnt);
        end
        on = 0;
        for (int i = 0; i < 20; i++) begin
            if (gate) on++;
            if (i == 1) begin
                tests++; if (cfg_ready !== 1'b0) begin
                    fails++; $display("FAIL b2b_second_capture: got %0b expected 0", cfg_ready);
                end
                cfg_valid = 1'b0;
            end
            if (i == 19) begin
                tests++; if (cnt !== 16'd19) begin fails++; $display("FAIL b2b_first_len: got %0d expected 19", cnt); end
            end
            @(negedge clk);
        end
        tests++; if (on != 5) begin fails++; $display("FAIL b2b_first_on: got %0d expected 5", on); end
        on = 0;
        for (int i = 0; i < 10; i++) begin
            if (gate) on++;
            @(negedge clk);
        end
        tests++; if (on != 8) begin fails++; $display("FAIL b2b_second_on: got %0d expected 8", on); end
        tests++; if (cnt !== 16'd0 || cfg_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_second_len: cnt %0d ready %0b expected 0 1", cnt, cfg_ready);
        end
    endtask

    task automatic test_drain();
        int bad;
        cfg_period = 16'd200; cfg_duty = 16'd100; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (9) @(negedge clk);
        tests++; if (cnt !== 16'd0 || period_start !== 1'b1) begin
            fails++; $display("FAIL drain_setup: cnt %0d ps %0b expected 0 1", cnt, period_start);
        end
        repeat (50) @(negedge clk);
        tests++; if (gate !== 1'b1 || cnt !== 16'd50) begin
            fails++; $display("FAIL drain_pre: gate %0b cnt %0d expected 1 50", gate, cnt);
        end
        en = 1'b0;
        @(negedge clk);
        tests++; if (gate !== 1'b0 || ss_done !== 1'b0) begin
            fails++; $display("FAIL drain_gate_off: gate %0b ss_done %0b expected 0 0", gate, ss_done);
        end
        bad = 0;
        for (int i = 51; i < 200; i++) begin
            if (gate !== 1'b0) bad++;
            if (int'(cnt) != i) bad++;
            @(negedge clk);
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL drain_run: got %0d bad samples expected 0", bad); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (cnt !== 16'd0) bad++;
            if (period_start !== 1'b0) bad++;
            @(negedge clk);
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL drain_idle: got %0d bad samples expected 0", bad); end
    endtask

    task automatic test_reset_midrun();
        int n, on;
        en = 1'b1;
        n = 0;
        while (ss_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        tests++; if (ss_done !== 1'b1) begin fails++; $display("FAIL rr_reach_run: got %0b expected 1", ss_done); end
        n = 0;
        while (cnt !== 16'd100 && n < 400) begin @(negedge clk); n++; end
        cfg_period = 16'd50; cfg_duty = 16'd10; cfg_valid = 1'b1;
        @(negedge clk);
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL rr_pending: got %0b expected 0", cfg_ready); end
        cfg_valid = 1'b0;
        repeat (19) @(negedge clk);
        tests++; if (cnt !== 16'd120) begin fails++; $display("FAIL rr_cnt120: got %0d expected 120", cnt); end
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        tests++; if (cnt !== 16'd0 || gate !== 1'b0 || period_start !== 1'b0 || ss_done !== 1'b0 || cfg_ready !== 1'b1) begin
            fails++; $display("FAIL rr_values: cnt %0d gate %0b ps %0b ss %0b ready %0b expected 0 0 0 0 1",
                              cnt, gate, period_start, ss_done, cfg_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (cfg_ready !== 1'b1 || cnt !== 16'd0) begin
            fails++; $display("FAIL rr_dropped: ready %0b cnt %0d expected 1 0", cfg_ready, cnt);
        end
        en = 1'b1;
        @(negedge clk);
        tests++; if (period_start !== 1'b1) begin fails++; $display("FAIL rr_restart: got %0b expected 1", period_start); end
        n = 0; on = 0;
        do begin
            if (gate) on++;
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < 1000);
        tests++; if (n != 200) begin fails++; $display("FAIL rr_period: got %0d expected 200", n); end
        tests++; if (on != 0) begin fails++; $display("FAIL rr_first_on: got %0d expected 0", on); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_duty = '0;
        test_reset();
        test_soft_start();
        test_cfg_apply();
        test_min_clamp();
        test_back_to_back();
        test_drain();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
